// File: rtl/corr_acc_multi.sv
// Multi-channel BOC/PRN correlation accumulator: coherent I/Q sums per channel, I^2+Q^2 non-coherent power, optional peak search.
// Define CORR_ACC_PEAK_EN to build the SCAN state and the tx_peak_idx / tx_peak_pow outputs.
module corr_acc_multi #(
   parameter int DAT_WIDTH  = 16,
   parameter int CORR_WIDTH = 32,
   parameter int POW_WIDTH  = 48,
   parameter int POW_SHIFT  = 16,
   parameter int NUM_CH     = 3,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          rx_clk,
   input  logic                          rx_rst,
   input  logic                          rx_src_valid,
   input  logic signed [DAT_WIDTH-1:0]   rx_src_cos,
   input  logic signed [DAT_WIDTH-1:0]   rx_src_sin,
   input  logic [NUM_CH-1:0]             rx_loc_boc,
   input  logic                          rx_prn_sop,
   input  logic                          rx_prn_eop,
   input  logic [7:0]                    cfg_coh_num,
   input  logic [7:0]                    cfg_ncoh_num,
   output logic [NUM_CH*POW_WIDTH-1:0]   tx_pow,
   output logic                          tx_pow_valid,
   output logic [CH_W-1:0]               tx_peak_idx,
   output logic [POW_WIDTH-1:0]          tx_peak_pow,
   output logic                          tx_resync,
   output logic                          tx_ovf
);

   localparam int SQ_W  = 2 * CORR_WIDTH;
   localparam int SUM_W = SQ_W + 1;

   typedef enum logic {IDLE, ACC} sync_state_e;
   typedef enum logic [2:0] {P_IDLE, SQ, ADD, SCAN, OUT} post_state_e;

   function automatic logic [SQ_W-1:0] square(input logic signed [CORR_WIDTH-1:0] v);
      logic signed [SQ_W-1:0] ve;
      ve = SQ_W'(v);
      return SQ_W'(ve * ve);
   endfunction

   // (I^2 + Q^2) >> POW_SHIFT, clamped to the power width.
   function automatic logic [POW_WIDTH-1:0] pow_of(input logic [SQ_W-1:0] a, input logic [SQ_W-1:0] b);
      logic [SUM_W-1:0] s;
      s = ({1'b0, a} + {1'b0, b}) >> POW_SHIFT;
      if ((s >> POW_WIDTH) != '0) return '1;
      return POW_WIDTH'(s);
   endfunction

   function automatic logic [POW_WIDTH-1:0] sat_add(input logic [POW_WIDTH-1:0] a, input logic [POW_WIDTH-1:0] b);
      logic [POW_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[POW_WIDTH]) return '1;
      return s[POW_WIDTH-1:0];
   endfunction

   // ---------------- coherent path ----------------
   sync_state_e                   sync_state_q, sync_state_d;
   logic                          prev_eop_q, prev_eop_d;
   logic [7:0]                    coh_cnt_q, coh_cnt_d, coh_base;
   logic [7:0]                    coh_max, ncoh_max;
   logic signed [CORR_WIDTH-1:0]  acc_cos_q [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  acc_sin_q [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  acc_cos_d [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  acc_sin_d [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  sum_cos   [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  sum_sin   [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  cos_ext, sin_ext;
   logic                          start_evt, resync_evt, dump_evt;

   assign coh_max  = (cfg_coh_num  == 8'd0) ? 8'd1 : cfg_coh_num;
   assign ncoh_max = (cfg_ncoh_num == 8'd0) ? 8'd1 : cfg_ncoh_num;
   assign cos_ext  = CORR_WIDTH'(rx_src_cos);
   assign sin_ext  = CORR_WIDTH'(rx_src_sin);

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      sync_state_d = sync_state_q;
      prev_eop_d   = prev_eop_q;
      coh_cnt_d    = coh_cnt_q;
      coh_base     = coh_cnt_q;
      start_evt    = 1'b0;
      resync_evt   = 1'b0;
      dump_evt     = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         sum_cos[k]   = acc_cos_q[k];
         sum_sin[k]   = acc_sin_q[k];
         acc_cos_d[k] = acc_cos_q[k];
         acc_sin_d[k] = acc_sin_q[k];
      end
      if (rx_src_valid) begin
         prev_eop_d = rx_prn_eop;
         if (sync_state_q == IDLE) begin
            if (rx_prn_sop) begin
               start_evt    = 1'b1;
               sync_state_d = ACC;
            end
         end else if (rx_prn_sop && !prev_eop_q) begin
            start_evt  = 1'b1;
            resync_evt = 1'b1;
         end
         if (sync_state_q == ACC || start_evt) begin
            coh_base = start_evt ? 8'd0 : coh_cnt_q;
            for (int k = 0; k < NUM_CH; k++) begin
               sum_cos[k] = (start_evt ? {CORR_WIDTH{1'b0}} : acc_cos_q[k]) + (rx_loc_boc[k] ? cos_ext : -cos_ext);
               sum_sin[k] = (start_evt ? {CORR_WIDTH{1'b0}} : acc_sin_q[k]) + (rx_loc_boc[k] ? sin_ext : -sin_ext);
            end
            if (rx_prn_eop && coh_base >= coh_max - 8'd1) begin
               dump_evt  = 1'b1;
               coh_cnt_d = 8'd0;
            end else if (rx_prn_eop) begin
               coh_cnt_d = coh_base + 8'd1;
            end else begin
               coh_cnt_d = coh_base;
            end
            for (int k = 0; k < NUM_CH; k++) begin
               acc_cos_d[k] = dump_evt ? {CORR_WIDTH{1'b0}} : sum_cos[k];
               acc_sin_d[k] = dump_evt ? {CORR_WIDTH{1'b0}} : sum_sin[k];
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         sync_state_q <= IDLE;
         prev_eop_q   <= 1'b0;
         coh_cnt_q    <= 8'd0;
         for (int k = 0; k < NUM_CH; k++) begin
            acc_cos_q[k] <= '0;
            acc_sin_q[k] <= '0;
         end
      end else begin
         sync_state_q <= sync_state_d;
         prev_eop_q   <= prev_eop_d;
         coh_cnt_q    <= coh_cnt_d;
         for (int k = 0; k < NUM_CH; k++) begin
            acc_cos_q[k] <= acc_cos_d[k];
            acc_sin_q[k] <= acc_sin_d[k];
         end
      end
   end

   // ---------------- post-processing path ----------------
   post_state_e                   post_q, post_d;
   logic [7:0]                    ncoh_cnt_q;
   logic signed [CORR_WIDTH-1:0]  dump_cos_q [NUM_CH];
   logic signed [CORR_WIDTH-1:0]  dump_sin_q [NUM_CH];
   logic [SQ_W-1:0]               sq_cos_q   [NUM_CH];
   logic [SQ_W-1:0]               sq_sin_q   [NUM_CH];
   logic [POW_WIDTH-1:0]          ncoh_sum_q [NUM_CH];
   logic [POW_WIDTH-1:0]          tx_pow_q   [NUM_CH];
   logic                          tx_pow_valid_q, tx_resync_q, tx_ovf_q;
   logic                          dump_take, ovf_evt, ncoh_done;

   // A resync aborts any in-flight post-processing, so a coincident dump is always accepted.
   assign dump_take = dump_evt && (post_q == P_IDLE || resync_evt);
   assign ovf_evt   = dump_evt && !dump_take;
   assign ncoh_done = (ncoh_cnt_q >= ncoh_max - 8'd1);

`ifdef CORR_ACC_PEAK_EN
   logic [CH_W-1:0]      scan_idx_q, best_idx_q, tx_peak_idx_q;
   logic [POW_WIDTH-1:0] best_pow_q, tx_peak_pow_q;
   logic                 scan_last;

   assign scan_last   = (scan_idx_q == CH_W'(NUM_CH - 1));
   assign tx_peak_idx = tx_peak_idx_q;
   assign tx_peak_pow = tx_peak_pow_q;
`else
   assign tx_peak_idx = '0;
   assign tx_peak_pow = '0;
`endif

   always_comb begin
      post_d = post_q;
      unique case (post_q)
         P_IDLE: if (dump_take) post_d = SQ;
         SQ:     post_d = ADD;
`ifdef CORR_ACC_PEAK_EN
         ADD:    post_d = ncoh_done ? SCAN : P_IDLE;
         SCAN:   if (scan_last) post_d = OUT;
`else
         ADD:    post_d = ncoh_done ? OUT : P_IDLE;
`endif
         OUT:    post_d = P_IDLE;
         default: post_d = P_IDLE;
      endcase
      if (resync_evt) post_d = dump_take ? SQ : P_IDLE;
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) post_q <= P_IDLE;
      else        post_q <= post_d;
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         // NOTE: the per-channel arrays are plain registers, so clearing them on reset is cheap and makes a mid-run reset discard everything.
         for (int k = 0; k < NUM_CH; k++) begin
            dump_cos_q[k] <= '0;
            dump_sin_q[k] <= '0;
            sq_cos_q[k]   <= '0;
            sq_sin_q[k]   <= '0;
            ncoh_sum_q[k] <= '0;
            tx_pow_q[k]   <= '0;
         end
         ncoh_cnt_q     <= 8'd0;
         tx_pow_valid_q <= 1'b0;
         tx_resync_q    <= 1'b0;
         tx_ovf_q       <= 1'b0;
`ifdef CORR_ACC_PEAK_EN
         scan_idx_q     <= '0;
         best_idx_q     <= '0;
         best_pow_q     <= '0;
         tx_peak_idx_q  <= '0;
         tx_peak_pow_q  <= '0;
`endif
      end else begin
         tx_pow_valid_q <= 1'b0;
         tx_resync_q    <= resync_evt;
         if (ovf_evt) tx_ovf_q <= 1'b1;
         if (dump_take) begin
            for (int k = 0; k < NUM_CH; k++) begin
               dump_cos_q[k] <= sum_cos[k];
               dump_sin_q[k] <= sum_sin[k];
            end
         end
         unique case (post_q)
            SQ: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  sq_cos_q[k] <= square(dump_cos_q[k]);
                  sq_sin_q[k] <= square(dump_sin_q[k]);
               end
            end
            ADD: begin
               for (int k = 0; k < NUM_CH; k++)
                  ncoh_sum_q[k] <= sat_add(ncoh_sum_q[k], pow_of(sq_cos_q[k], sq_sin_q[k]));
               ncoh_cnt_q <= ncoh_cnt_q + 8'd1;
            end
`ifdef CORR_ACC_PEAK_EN
            SCAN: begin
               // Strict greater-than keeps the lowest index on ties.
               if (scan_idx_q == '0 || ncoh_sum_q[scan_idx_q] > best_pow_q) begin
                  best_idx_q <= scan_idx_q;
                  best_pow_q <= ncoh_sum_q[scan_idx_q];
               end
               scan_idx_q <= scan_last ? '0 : scan_idx_q + CH_W'(1);
            end
`endif
            OUT: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  tx_pow_q[k]   <= ncoh_sum_q[k];
                  ncoh_sum_q[k] <= '0;
               end
               ncoh_cnt_q     <= 8'd0;
               tx_pow_valid_q <= 1'b1;
`ifdef CORR_ACC_PEAK_EN
               tx_peak_idx_q  <= best_idx_q;
               tx_peak_pow_q  <= best_pow_q;
`endif
            end
            default: ;
         endcase
         if (resync_evt) begin
            for (int k = 0; k < NUM_CH; k++) ncoh_sum_q[k] <= '0;
            ncoh_cnt_q <= 8'd0;
`ifdef CORR_ACC_PEAK_EN
            scan_idx_q <= '0;
`endif
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign tx_pow[k*POW_WIDTH +: POW_WIDTH] = tx_pow_q[k];
   end

   assign tx_pow_valid = tx_pow_valid_q;
   assign tx_resync    = tx_resync_q;
   assign tx_ovf       = tx_ovf_q;

endmodule

// File: tb/tb_corr_acc_multi.sv
// Scoreboard bench for corr_acc_multi: a 48-bit instance and a 20-bit instance driven by the same directed vectors.
module tb_corr_acc_multi;

   localparam int NUM_CH = 3;
   localparam int PW     = 48;
   localparam int SPW    = 20;
`ifdef CORR_ACC_PEAK_EN
   localparam int LAT     = NUM_CH + 3;
   localparam int OVF_LEN = 4;
`else
   localparam int LAT     = 3;
   localparam int OVF_LEN = 3;
`endif

   logic rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   logic                      rx_rst;
   logic                      rx_src_valid;
   logic signed [15:0]        rx_src_cos, rx_src_sin;
   logic [NUM_CH-1:0]         rx_loc_boc;
   logic                      rx_prn_sop, rx_prn_eop;
   logic [7:0]                cfg_coh_num, cfg_ncoh_num;

   logic [NUM_CH*PW-1:0]      tx_pow;
   logic                      tx_pow_valid;
   logic [1:0]                tx_peak_idx;
   logic [PW-1:0]             tx_peak_pow;
   logic                      tx_resync, tx_ovf;

   logic [NUM_CH*SPW-1:0]     s_pow;
   logic                      s_pow_valid;
   logic [1:0]                s_peak_idx;
   logic [SPW-1:0]            s_peak_pow;
   logic                      s_resync, s_ovf;

   corr_acc_multi #(.POW_SHIFT(0), .NUM_CH(NUM_CH), .POW_WIDTH(PW)) u_dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_src_valid(rx_src_valid),
      .rx_src_cos(rx_src_cos), .rx_src_sin(rx_src_sin), .rx_loc_boc(rx_loc_boc),
      .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop),
      .cfg_coh_num(cfg_coh_num), .cfg_ncoh_num(cfg_ncoh_num),
      .tx_pow(tx_pow), .tx_pow_valid(tx_pow_valid), .tx_peak_idx(tx_peak_idx),
      .tx_peak_pow(tx_peak_pow), .tx_resync(tx_resync), .tx_ovf(tx_ovf)
   );

   corr_acc_multi #(.POW_SHIFT(0), .NUM_CH(NUM_CH), .POW_WIDTH(SPW)) u_sat (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_src_valid(rx_src_valid),
      .rx_src_cos(rx_src_cos), .rx_src_sin(rx_src_sin), .rx_loc_boc(rx_loc_boc),
      .rx_prn_sop(rx_prn_sop), .rx_prn_eop(rx_prn_eop),
      .cfg_coh_num(cfg_coh_num), .cfg_ncoh_num(cfg_ncoh_num),
      .tx_pow(s_pow), .tx_pow_valid(s_pow_valid), .tx_peak_idx(s_peak_idx),
      .tx_peak_pow(s_peak_pow), .tx_resync(s_resync), .tx_ovf(s_ovf)
   );

   typedef struct {
      logic [NUM_CH*PW-1:0] pow;
      longint               e_cyc;
   } exp_t;

   exp_t                  exp_q[$];
   logic [NUM_CH*SPW-1:0] sat_q[$];
   int                    n_tests = 0;
   int                    n_fail  = 0;
   longint                cyc     = 0;

   always @(posedge rx_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int peak_of(input logic [NUM_CH*PW-1:0] p);
      int idx = 0;
      for (int k = 1; k < NUM_CH; k++)
         if (p[k*PW +: PW] > p[idx*PW +: PW]) idx = k;
      return idx;
   endfunction

   task automatic push_exp(input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [PW-1:0] p2, input longint e);
      exp_t                  x;
      logic [PW-1:0]         p [NUM_CH];
      logic [NUM_CH*SPW-1:0] s;
      logic [PW-1:0]         smax;
      smax = (PW'(1) << SPW) - PW'(1);
      p[0] = p0; p[1] = p1; p[2] = p2;
      for (int k = 0; k < NUM_CH; k++) begin
         x.pow[k*PW +: PW]  = p[k];
         s[k*SPW +: SPW]    = SPW'((p[k] > smax) ? smax : p[k]);
      end
      x.e_cyc = e;
      exp_q.push_back(x);
      sat_q.push_back(s);
   endtask

   // Monitor: pops the scoreboard whenever either instance strobes.
   always @(negedge rx_clk) begin
      exp_t                  e;
      logic [NUM_CH*SPW-1:0] se;
      if (!rx_rst && tx_pow_valid) begin
         if (exp_q.size() == 0) begin
            check("main_unexpected_strobe", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < NUM_CH; k++)
               check($sformatf("main_pow_ch%0d", k), 64'(tx_pow[k*PW +: PW]), 64'(e.pow[k*PW +: PW]));
`ifdef CORR_ACC_PEAK_EN
            check("peak_idx", 64'(tx_peak_idx), 64'(peak_of(e.pow)));
            check("peak_pow", 64'(tx_peak_pow), 64'(e.pow[peak_of(e.pow)*PW +: PW]));
`else
            check("peak_idx_tied", 64'(tx_peak_idx), 64'd0);
            check("peak_pow_tied", 64'(tx_peak_pow), 64'd0);
`endif
            check("latency", 64'(cyc - e.e_cyc), 64'(LAT));
         end
      end
      if (!rx_rst && s_pow_valid) begin
         if (sat_q.size() == 0) begin
            check("sat_unexpected_strobe", 64'd1, 64'd0);
         end else begin
            se = sat_q.pop_front();
            for (int k = 0; k < NUM_CH; k++)
               check($sformatf("sat_pow_ch%0d", k), 64'(s_pow[k*SPW +: SPW]), 64'(se[k*SPW +: SPW]));
         end
      end
   end

   task automatic send(input int c, input int s, input logic [NUM_CH-1:0] boc, input logic sp, input logic ep);
      rx_src_valid = 1'b1;
      rx_src_cos   = 16'(c);
      rx_src_sin   = 16'(s);
      rx_loc_boc   = boc;
      rx_prn_sop   = sp;
      rx_prn_eop   = ep;
      @(posedge rx_clk);
      #1;
      rx_src_valid = 1'b0;
      rx_prn_sop   = 1'b0;
      rx_prn_eop   = 1'b0;
   endtask

   task automatic period(input int len, input int c, input int s, input bit mixed);
      logic [NUM_CH-1:0] boc;
      for (int i = 0; i < len; i++) begin
         boc = mixed ? {~i[0], 1'b0, 1'b1} : 3'b111;
         send(c, s, boc, i == 0, i == len - 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge rx_clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pow"},       64'(tx_pow[63:0]), 64'd0);
      check({tag, "_pow_hi"},    64'(tx_pow[NUM_CH*PW-1:64]), 64'd0);
      check({tag, "_valid"},     64'(tx_pow_valid), 64'd0);
      check({tag, "_peak_idx"},  64'(tx_peak_idx), 64'd0);
      check({tag, "_peak_pow"},  64'(tx_peak_pow), 64'd0);
      check({tag, "_resync"},    64'(tx_resync), 64'd0);
      check({tag, "_ovf"},       64'(tx_ovf), 64'd0);
   endtask

   initial begin
      longint p_ovf;
      rx_rst       = 1'b1;
      rx_src_valid = 1'b0;
      rx_src_cos   = '0;
      rx_src_sin   = '0;
      rx_loc_boc   = '0;
      rx_prn_sop   = 1'b0;
      rx_prn_eop   = 1'b0;
      cfg_coh_num  = 8'd1;
      cfg_ncoh_num = 8'd1;
      repeat (3) @(posedge rx_clk);
      #1;
      check_outputs_zero("reset");
      rx_rst = 1'b0;
      idle(2);

      // All replicas +1, cfg 0 behaves as 1: each channel I=1000 -> 1,000,000.
      cfg_coh_num = 8'd0; cfg_ncoh_num = 8'd0;
      period(10, 100, 0, 1'b0);
      push_exp(1000000, 1000000, 1000000, cyc);
      idle(12);

      // ch0 +, ch1 -, ch2 alternating: 1e6, 1e6, 0 (tie -> lowest index).
      cfg_coh_num = 8'd1; cfg_ncoh_num = 8'd1;
      period(10, 100, 0, 1'b1);
      push_exp(1000000, 1000000, 0, cyc);
      idle(12);

      // coh=2, ncoh=3, I=Q=2000 per dump: 3 * 8e6 = 24e6; 20-bit instance saturates.
      cfg_coh_num = 8'd2; cfg_ncoh_num = 8'd3;
      for (int p = 0; p < 6; p++) begin
         period(10, 100, 100, 1'b0);
         if (p == 5) push_exp(24000000, 24000000, 24000000, cyc);
      end
      idle(20);

      // Resync: one dump into the ncoh sum, a 5-sample partial period, then a new sop.
      cfg_coh_num = 8'd1; cfg_ncoh_num = 8'd2;
      period(10, 100, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(100, 0, 3'b111, i == 0, 1'b0);
         if (i == 0) check("resync_quiet_after_eop", 64'(tx_resync), 64'd0);
      end
      send(100, 0, 3'b111, 1'b1, 1'b0);
      check("resync_pulse", 64'(tx_resync), 64'd1);
      for (int i = 1; i < 10; i++) begin
         send(100, 0, 3'b111, 1'b0, i == 9);
         if (i == 1) check("resync_one_cycle", 64'(tx_resync), 64'd0);
      end
      period(10, 100, 0, 1'b0);
      push_exp(2000000, 2000000, 2000000, cyc);
      idle(20);

      // Overflow: back-to-back short periods, the second dump is dropped.
      cfg_coh_num = 8'd1; cfg_ncoh_num = 8'd1;
      p_ovf = longint'(100 * OVF_LEN) * longint'(100 * OVF_LEN);
      period(OVF_LEN, 100, 0, 1'b0);
      push_exp(PW'(p_ovf), PW'(p_ovf), PW'(p_ovf), cyc);
      check("ovf_clear_before_drop", 64'(tx_ovf), 64'd0);
      period(OVF_LEN, 100, 0, 1'b0);
      check("ovf_set_on_drop", 64'(tx_ovf), 64'd1);
      period(OVF_LEN, 100, 0, 1'b0);
      push_exp(PW'(p_ovf), PW'(p_ovf), PW'(p_ovf), cyc);
      idle(20);
      check("ovf_sticky", 64'(tx_ovf), 64'd1);
      check("sat_ovf_sticky", 64'(s_ovf), 64'd1);

      // Reset mid-block: outputs clear at once, the orphaned tail is ignored.
      for (int i = 0; i < 5; i++) send(100, 0, 3'b111, i == 0, 1'b0);
      rx_rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      check("midrst_sat_ovf", 64'(s_ovf), 64'd0);
      @(posedge rx_clk);
      #1;
      rx_rst = 1'b0;
      for (int i = 5; i < 10; i++) send(100, 0, 3'b111, 1'b0, i == 9);
      idle(20);
      period(10, 100, 0, 1'b0);
      push_exp(1000000, 1000000, 1000000, cyc);
      idle(20);

      for (int i = 0; i < 200 && (exp_q.size() != 0 || sat_q.size() != 0); i++)
         @(posedge rx_clk);
      #1;
      check("main_results_outstanding", 64'(exp_q.size()), 64'd0);
      check("sat_results_outstanding", 64'(sat_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/corr_acc_multi.md
# corr_acc_multi

Multi-channel BOC/PRN correlation accumulator for the B1 acquisition and tracking path. It correlates the carrier-wiped I/Q samples against NUM_CH local replica bits (for example early/prompt/late, or several code-phase lags). It accumulates coherently over a programmable number of PRN periods, then sums I²+Q² non-coherently over a programmable number of dumps. Each result is delivered with a one-cycle valid strobe and, optionally, the strongest channel. It sits between the carrier mixer and the acquisition/tracking controller.

## Interface
- DAT_WIDTH, 16: signed input sample width
- CORR_WIDTH, 32: signed coherent accumulator width
- POW_WIDTH, 48: unsigned power / non-coherent accumulator width
- POW_SHIFT, 16: right shift applied to I²+Q² before non-coherent add
- NUM_CH, 3: number of correlator channels (≥1)
- CH_W, $clog2(NUM_CH) (min 1): channel index width

Ports:
- rx_clk  in  1  clock
- rx_rst  in  1  asynchronous, active-high reset
- rx_src_valid  in  1  sample strobe; all rx_* sample-domain inputs are ignored when low
- rx_src_cos, rx_src_sin  in  DAT_WIDTH  signed I/Q sample
- rx_loc_boc  in  NUM_CH  per-channel replica bit; 1 = add, 0 = subtract
- rx_prn_sop  in  1  first sample of a PRN period (qualified by valid)
- rx_prn_eop  in  1  last sample of a PRN period (qualified by valid); may coincide with sop
- cfg_coh_num  in  8  PRN periods per coherent dump; 0 treated as 1
- cfg_ncoh_num  in  8  dumps per non-coherent result; 0 treated as 1
- tx_pow  out  NUM_CH*POW_WIDTH  non-coherent power, channel k at bits [k*POW_WIDTH +: POW_WIDTH]
- tx_pow_valid  out  1  one-cycle strobe; tx_pow / tx_peak_* valid while high
- tx_peak_idx  out  CH_W  channel with maximum power
- tx_peak_pow  out  POW_WIDTH  power of that channel
- tx_resync  out  1  one-cycle pulse on loss of PRN sync
- tx_ovf  out  1  sticky; set when a dump is dropped; cleared only by rx_rst

## Operation
- Reset: all outputs 0; accumulators and counters 0; sync FSM in IDLE; post FSM in P_IDLE. Reset may assert mid-operation: any partial coherent block or non-coherent sum is discarded.
- Sync FSM, states IDLE and ACC:
  - IDLE → ACC on valid&sop. That sample loads each channel: acc = ±sample.
  - In ACC, each valid sample adds or subtracts per rx_loc_boc[k]. Sign extension is to CORR_WIDTH; arithmetic is two's complement and wraps.
- Period counting: valid&eop increments coh_cnt.
  - When coh_cnt reaches max(cfg_coh_num,1)−1, the updated sums (including the eop sample) load the dump registers. Accumulators clear so the next valid sample loads fresh, and coh_cnt returns to 0.
- Resync: valid&sop while the previous valid sample was not eop:
  - tx_resync pulses.
  - The partial block and non-coherent sum are discarded; coh_cnt and ncoh_cnt are cleared.
  - Accumulation restarts from this sample.
- Post FSM: P_IDLE → SQ → ADD → (SCAN → OUT | P_IDLE).
  - SQ: register I² and Q² per channel (full 2*CORR_WIDTH).
  - ADD: p = (I²+Q²) >> POW_SHIFT, saturated to POW_WIDTH, then added to the non-coherent sum with saturation at all-ones. ncoh_cnt increments.
    - If the count is not yet reached → P_IDLE.
    - If it is reached → SCAN.
  - SCAN: sequential compare over NUM_CH cycles, one channel per cycle. Strict greater-than is used, so ties keep the lowest index.
  - OUT: tx_pow, tx_peak_* update, tx_pow_valid high one cycle, non-coherent sums and ncoh_cnt clear → P_IDLE.
- Overflow: a dump while the post FSM is not in P_IDLE is dropped and tx_ovf sets. The coherent path is unaffected. Back-to-back dumps therefore require ≥ NUM_CH+4 cycles between dump events.
- cfg_* are sampled at the dump and ADD decisions; change them only between results.

## Timing
- Latencies are measured from edge E, the edge that captures the final eop sample of a block:
  - Dump registers load at E.
  - Squares at E+1.
  - Non-coherent add at E+2.
  - Scan at E+3..E+2+NUM_CH.
  - tx_pow_valid high in the cycle after edge E+3+NUM_CH.
- tx_resync asserts in the cycle after the offending sop edge.
- tx_ovf asserts in the cycle after the dropped dump edge.
- Outputs hold their values between strobes.

## Configuration
- CORR_ACC_PEAK_EN defined: SCAN state present; tx_peak_idx / tx_peak_pow as above.
- Not defined: SCAN omitted (ADD → OUT directly); tx_peak_idx and tx_peak_pow tied 0; tx_pow_valid latency becomes E+4. Overflow spacing requirement becomes ≥4 cycles.

## Test plan
- NUM_CH=3, POW_SHIFT=0, rx_loc_boc=3'b111, cos=100, sin=0, 10-sample periods, coh=1, ncoh=1 → each channel 1,000,000; peak idx 0; valid 7 cycles after eop edge (PEAK_EN).
- rx_loc_boc ch0=1, ch1=0, ch2 alternating 1/0; same stimulus → ch0 = ch1 = 1,000,000, ch2 = 0, tx_peak_idx=0 (tie, lowest index).
- coh=2, ncoh=3, cos=100, sin=100, 10-sample periods → per dump I=Q=2000; tx_pow = 3×8,000,000 = 24,000,000; one strobe per 60 samples.
- sop injected at sample 5 of a period → tx_resync pulse; next result needs full coh×ncoh periods counted from the new sop.
- NUM_CH=3, 4-sample periods, coh=1 → second dump dropped, tx_ovf=1 and held until rx_rst. Separately, POW_WIDTH=20 with cos=32767 → tx_pow saturates at 20'hFFFFF.
- rx_rst asserted mid-block → all outputs 0 next cycle; no strobe until a new sop plus a full block.
